// File: rtl/mandelbrot_pkg.sv
// Shared types and helpers for the multi-lane Mandelbrot frame engine.
package mandelbrot_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ITER  = 2'd2,
        DRAIN = 2'd3
    } state_e;

    // Limit the counter-slice select so the slice never runs past the counter MSB.
    function automatic int unsigned clamp_sel(input int unsigned sel, input int unsigned max_sel);
        return (sel > max_sel) ? max_sel : sel;
    endfunction

endpackage

// File: rtl/mandelbrot_alu.sv
// One Mandelbrot step z' = z^2 + c in two's complement with BITWIDTH-3 fraction bits.
// size flags |z|^2 > 4 for the current z; overflow flags a z' that wrapped.
module mandelbrot_alu #(
    parameter int unsigned BITWIDTH = 10
) (
    input  logic signed [BITWIDTH-1:0] zr_i,
    input  logic signed [BITWIDTH-1:0] zi_i,
    input  logic signed [BITWIDTH-1:0] cr_i,
    input  logic signed [BITWIDTH-1:0] ci_i,
    output logic signed [BITWIDTH-1:0] zr_o,
    output logic signed [BITWIDTH-1:0] zi_o,
    output logic                       size_o,
    output logic                       overflow_o
);
    localparam int unsigned FRAC    = BITWIDTH - 3;
    localparam int unsigned PW      = 2 * BITWIDTH + 2;
    localparam int          FOUR_SQ = 4 << (2 * FRAC);

    logic signed [PW-1:0] zr_w, zi_w, zr2, zi2, zri, nr_full, ni_full;

    always_comb begin
        zr_w       = PW'(zr_i);
        zi_w       = PW'(zi_i);
        zr2        = zr_w * zr_w;
        zi2        = zi_w * zi_w;
        zri        = zr_w * zi_w;
        nr_full    = ((zr2 - zi2) >>> FRAC) + PW'(cr_i);
        ni_full    = (zri >>> (FRAC - 1)) + PW'(ci_i);
        zr_o       = nr_full[BITWIDTH-1:0];
        zi_o       = ni_full[BITWIDTH-1:0];
        size_o     = (zr2 + zi2) > PW'(FOUR_SQ);
        overflow_o = (nr_full != PW'(zr_o)) || (ni_full != PW'(zi_o));
    end

endmodule

// File: rtl/mandelbrot_lane.sv
// One pixel lane: latches c on load, iterates until escape, limit or wrap, then holds ctr.
module mandelbrot_lane #(
    parameter int unsigned BITWIDTH = 10,
    parameter int unsigned CTRWIDTH = 7
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [BITWIDTH-1:0] cr,
    input  logic [BITWIDTH-1:0] ci,
    input  logic [CTRWIDTH-1:0] max_ctr,
    output logic [CTRWIDTH-1:0] ctr,
    output logic                done
);
    logic [BITWIDTH-1:0] zr_q, zr_d, zi_q, zi_d, cr_q, cr_d, ci_q, ci_d;
    logic [BITWIDTH-1:0] alu_zr, alu_zi;
    logic [CTRWIDTH-1:0] ctr_q, ctr_d;
    logic                ovf_q, ovf_d, done_q, done_d;
    logic                alu_size, alu_ovf, term_c;

    mandelbrot_alu #(.BITWIDTH(BITWIDTH)) u_alu (
        .zr_i       (zr_q),
        .zi_i       (zi_q),
        .cr_i       (cr_q),
        .ci_i       (ci_q),
        .zr_o       (alu_zr),
        .zi_o       (alu_zi),
        .size_o     (alu_size),
        .overflow_o (alu_ovf)
    );

    // Termination looks at the registered z, so a wrapped step costs one extra cycle.
    assign term_c = alu_size || (ctr_q == max_ctr) || ovf_q;
    assign ctr    = ctr_q;
    assign done   = done_q || term_c;

    always_comb begin
        zr_d   = zr_q;
        zi_d   = zi_q;
        cr_d   = cr_q;
        ci_d   = ci_q;
        ctr_d  = ctr_q;
        ovf_d  = ovf_q;
        done_d = done_q;
        if (load) begin
            zr_d   = '0;
            zi_d   = '0;
            cr_d   = cr;
            ci_d   = ci;
            ctr_d  = '0;
            ovf_d  = 1'b0;
            done_d = 1'b0;
        end else if (!done_q) begin
            if (term_c) begin
                done_d = 1'b1;
            end else begin
                zr_d  = alu_zr;
                zi_d  = alu_zi;
                ctr_d = ctr_q + CTRWIDTH'(1);
                ovf_d = alu_ovf;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zr_q   <= '0;
            zi_q   <= '0;
            cr_q   <= '0;
            ci_q   <= '0;
            ctr_q  <= '0;
            ovf_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            zr_q   <= zr_d;
            zi_q   <= zi_d;
            cr_q   <= cr_d;
            ci_q   <= ci_d;
            ctr_q  <= ctr_d;
            ovf_q  <= ovf_d;
            done_q <= done_d;
        end
    end

endmodule

// File: rtl/mandelbrot_multilane.sv
// Frame engine: LANES adjacent pixels per group, results streamed in raster order.
module mandelbrot_multilane
    import mandelbrot_pkg::*;
#(
    parameter  int unsigned BITWIDTH = 10,
    parameter  int unsigned CTRWIDTH = 7,
    parameter  int unsigned OUTWIDTH = 4,
    parameter  int unsigned WIDTH    = 320,
    parameter  int unsigned HEIGHT   = 240,
    parameter  int unsigned LANES    = 2,
    localparam int unsigned SELW     = $clog2(CTRWIDTH - OUTWIDTH + 1),
    localparam int unsigned XW       = $clog2(WIDTH),
    localparam int unsigned YW       = $clog2(HEIGHT)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    output logic                busy,
    input  logic [CTRWIDTH-1:0] max_ctr,
    input  logic [SELW-1:0]     ctr_select,
    input  logic [BITWIDTH-1:0] step,
    input  logic [BITWIDTH-1:0] cr_offset,
    input  logic [BITWIDTH-1:0] ci_offset,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUTWIDTH-1:0] out_ctr,
    output logic [XW-1:0]       out_x,
    output logic [YW-1:0]       out_y,
    output logic                out_last,
    output logic                frame_done
);
    localparam int unsigned JW     = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned MAXSEL = CTRWIDTH - OUTWIDTH;

    if ((WIDTH % LANES) != 0 || OUTWIDTH > CTRWIDTH || LANES < 1) begin : g_param_check
        $error("mandelbrot_multilane: WIDTH must be a multiple of LANES and OUTWIDTH <= CTRWIDTH");
    end

    state_e              state_q, state_d;
    logic [CTRWIDTH-1:0] max_ctr_q, max_ctr_d;
    logic [SELW-1:0]     sel_q, sel_d;
    logic [BITWIDTH-1:0] step_q, step_d, cr_off_q, cr_off_d, cr_base_q, cr_base_d, ci_q, ci_d;
    logic [XW-1:0]       gx_q, gx_d, out_x_q, out_x_d;
    logic [YW-1:0]       y_q, y_d, out_y_q, out_y_d;
    logic [JW-1:0]       j_q, j_d, nxt_j;
    logic [OUTWIDTH-1:0] out_ctr_q, out_ctr_d;
    logic                out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic                frame_done_q, frame_done_d, busy_q, busy_d;
    logic                load_c, line_end_c, last_group_c;

    logic [BITWIDTH-1:0] lane_cr  [LANES];
    logic [CTRWIDTH-1:0] lane_ctr [LANES];
    logic [LANES-1:0]    lane_done;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign lane_cr[k] = cr_base_q + BITWIDTH'(k) * step_q;
        mandelbrot_lane #(.BITWIDTH(BITWIDTH), .CTRWIDTH(CTRWIDTH)) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .load    (load_c),
            .cr      (lane_cr[k]),
            .ci      (ci_q),
            .max_ctr (max_ctr_q),
            .ctr     (lane_ctr[k]),
            .done    (lane_done[k])
        );
    end

    function automatic logic [OUTWIDTH-1:0] slice(input logic [CTRWIDTH-1:0] c, input logic [SELW-1:0] s);
        return OUTWIDTH'(c >> s);
    endfunction

    assign line_end_c   = (gx_q == XW'(WIDTH - LANES));
    assign last_group_c = line_end_c && (y_q == YW'(HEIGHT - 1));
    assign nxt_j        = j_q + JW'(1);

    always_comb begin
        state_d      = state_q;
        max_ctr_d    = max_ctr_q;
        sel_d        = sel_q;
        step_d       = step_q;
        cr_off_d     = cr_off_q;
        cr_base_d    = cr_base_q;
        ci_d         = ci_q;
        gx_d         = gx_q;
        y_d          = y_q;
        j_d          = j_q;
        out_valid_d  = out_valid_q;
        out_ctr_d    = out_ctr_q;
        out_x_d      = out_x_q;
        out_y_d      = out_y_q;
        out_last_d   = out_last_q;
        frame_done_d = 1'b0;
        load_c       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    max_ctr_d = max_ctr;
                    sel_d     = SELW'(clamp_sel(32'(ctr_select), MAXSEL));
                    step_d    = step;
                    cr_off_d  = cr_offset;
                    cr_base_d = cr_offset;
                    ci_d      = ci_offset;
                    gx_d      = '0;
                    y_d       = '0;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                load_c  = 1'b1;
                state_d = ITER;
            end
            ITER: begin
                if (&lane_done) begin
                    j_d         = '0;
                    out_valid_d = 1'b1;
                    out_ctr_d   = slice(lane_ctr[0], sel_q);
                    out_x_d     = gx_q;
                    out_y_d     = y_q;
                    out_last_d  = last_group_c && (LANES == 1);
                    state_d     = DRAIN;
                end
            end
            DRAIN: begin
                if (out_valid_q && out_ready) begin
                    if (j_q == JW'(LANES - 1)) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        if (last_group_c) begin
                            frame_done_d = 1'b1;
                            state_d      = IDLE;
                        end else begin
                            state_d = LOAD;
                            // Wrap to the next line or step the group base along it.
                            if (line_end_c) begin
                                gx_d      = '0;
                                cr_base_d = cr_off_q;
                                ci_d      = ci_q + step_q;
                                y_d       = y_q + YW'(1);
                            end else begin
                                gx_d      = gx_q + XW'(LANES);
                                cr_base_d = cr_base_q + BITWIDTH'(LANES) * step_q;
                            end
                        end
                    end else begin
                        j_d        = nxt_j;
                        out_ctr_d  = slice(lane_ctr[nxt_j], sel_q);
                        out_x_d    = gx_q + XW'(nxt_j);
                        out_last_d = last_group_c && (nxt_j == JW'(LANES - 1));
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Abort beats any same-cycle transfer; the pending pixel is dropped.
        if (abort && state_q != IDLE) begin
            state_d      = IDLE;
            out_valid_d  = 1'b0;
            out_last_d   = 1'b0;
            frame_done_d = 1'b0;
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            max_ctr_q    <= '0;
            sel_q        <= '0;
            step_q       <= '0;
            cr_off_q     <= '0;
            cr_base_q    <= '0;
            ci_q         <= '0;
            gx_q         <= '0;
            y_q          <= '0;
            j_q          <= '0;
            out_valid_q  <= 1'b0;
            out_ctr_q    <= '0;
            out_x_q      <= '0;
            out_y_q      <= '0;
            out_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            max_ctr_q    <= max_ctr_d;
            sel_q        <= sel_d;
            step_q       <= step_d;
            cr_off_q     <= cr_off_d;
            cr_base_q    <= cr_base_d;
            ci_q         <= ci_d;
            gx_q         <= gx_d;
            y_q          <= y_d;
            j_q          <= j_d;
            out_valid_q  <= out_valid_d;
            out_ctr_q    <= out_ctr_d;
            out_x_q      <= out_x_d;
            out_y_q      <= out_y_d;
            out_last_q   <= out_last_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
        end
    end

    assign busy       = busy_q;
    assign out_valid  = out_valid_q;
    assign out_ctr    = out_ctr_q;
    assign out_x      = out_x_q;
    assign out_y      = out_y_q;
    assign out_last   = out_last_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_mandelbrot_multilane.sv
// Bench for mandelbrot_multilane: per-pixel escape-count model plus scoreboard on a 4x2 frame.
module tb_mandelbrot_multilane;
    localparam int W = 4;
    localparam int H = 2;
    localparam int L = 2;

    typedef struct {
        int ctr;
        int x;
        int y;
        int last;
    } pix_t;

    logic       clk = 1'b0;
    logic       rst_n, start, abort, busy;
    logic [6:0] max_ctr;
    logic [1:0] ctr_select;
    logic [9:0] step, cr_offset, ci_offset;
    logic       out_valid, out_ready, out_last, frame_done;
    logic [3:0] out_ctr;
    logic [1:0] out_x;
    logic [0:0] out_y;

    int   checks = 0;
    int   errors = 0;
    int   frames_seen = 0;
    int   frames_exp = 0;
    int   ready_mode = 0;
    pix_t exp_q[$];

    always #5 clk = ~clk;

    mandelbrot_multilane #(.WIDTH(W), .HEIGHT(H), .LANES(L)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .busy       (busy),
        .max_ctr    (max_ctr),
        .ctr_select (ctr_select),
        .step       (step),
        .cr_offset  (cr_offset),
        .ci_offset  (ci_offset),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_ctr    (out_ctr),
        .out_x      (out_x),
        .out_y      (out_y),
        .out_last   (out_last),
        .frame_done (frame_done)
    );

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint sx10(input longint v);
        return ((v & 1023) ^ 512) - 512;
    endfunction

    // Escape count of one pixel: Q3.7 z^2+c with wrap, stop on |z|^2>4, limit, or a wrapped step.
    function automatic int pix_ctr(input longint cr, input longint ci, input int maxc);
        longint zr = 0;
        longint zi = 0;
        longint nr, ni;
        bit     ovf = 1'b0;
        int     n = 0;
        while (!((zr * zr + zi * zi > 65536) || (n == maxc) || ovf)) begin
            nr  = ((zr * zr - zi * zi) >>> 7) + cr;
            ni  = ((zr * zi) >>> 6) + ci;
            ovf = (nr != sx10(nr)) || (ni != sx10(ni));
            zr  = sx10(nr);
            zi  = sx10(ni);
            n++;
        end
        return n;
    endfunction

    task automatic push_frame(input int maxc, input int sel, input int stp, input int cro, input int cio);
        pix_t e;
        int   s;
        int   c;
        s = (sel > 3) ? 3 : sel;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                c      = pix_ctr(sx10(cro + x * stp), sx10(cio + y * stp), maxc);
                e.ctr  = (c >> s) & 15;
                e.x    = x;
                e.y    = y;
                e.last = (x == W - 1 && y == H - 1) ? 1 : 0;
                exp_q.push_back(e);
            end
        end
    endtask

    // Compare process: scoreboard on every transfer, hold check while stalled.
    initial begin : cmp
        bit         prev_stall;
        logic [7:0] held;
        pix_t       e;
        prev_stall = 1'b0;
        held       = '0;
        forever begin
            @(negedge clk or negedge rst_n);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall)
                    check("stall_hold", {out_valid, out_ctr, out_x, out_y, out_last}, {1'b1, held});
                if (out_valid && out_ready && !abort) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_pixel", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("pix_ctr", out_ctr, e.ctr);
                        check("pix_x", out_x, e.x);
                        check("pix_y", out_y, e.y);
                        check("pix_last", out_last, e.last);
                    end
                end
                if (frame_done) begin
                    frames_seen++;
                    check("done_after_last", exp_q.size(), 0);
                end
                prev_stall = out_valid && !out_ready && !abort;
                held       = {out_ctr, out_x, out_y, out_last};
            end
        end
    end

    initial begin : ready_drv
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    task automatic run_frame(input int maxc, input int sel, input int stp, input int cro, input int cio,
                             input int rmode, input bit poke);
        bit done_seen;
        done_seen  = 1'b0;
        ready_mode = rmode;
        max_ctr    = 7'(maxc);
        ctr_select = 2'(sel);
        step       = 10'(stp);
        cr_offset  = 10'(cro);
        ci_offset  = 10'(cio);
        push_frame(maxc, sel, stp, cro, cio);
        frames_exp++;
        start = 1'b1;
        @(posedge clk);
        #1;
        start      = 1'b0;
        max_ctr    = 7'($urandom);
        ctr_select = 2'($urandom);
        step       = 10'($urandom);
        cr_offset  = 10'($urandom);
        ci_offset  = 10'($urandom);
        for (int n = 0; n < 20000 && !done_seen; n++) begin
            if (frame_done) begin
                done_seen = 1'b1;
            end else begin
                start = poke && busy && ($urandom_range(0, 7) == 0);
                @(posedge clk);
                #1;
            end
        end
        start = 1'b0;
        check("frame_completed", done_seen, 1);
        check("frame_pixels_left", exp_q.size(), 0);
        exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic abort_test(input bit in_drain);
        int f0;
        bit got;
        f0         = frames_seen;
        got        = 1'b0;
        ready_mode = 2;
        max_ctr    = 7'd127;
        ctr_select = 2'd0;
        step       = '0;
        cr_offset  = '0;
        ci_offset  = '0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (in_drain) begin
            for (int n = 0; n < 1000 && !got; n++) begin
                @(posedge clk);
                #1;
                got = out_valid;
            end
            check("drain_reached", got, 1);
        end else begin
            repeat (20) begin
                @(posedge clk);
                #1;
            end
            check("iter_busy", {busy, out_valid}, 2'b10);
        end
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_valid", out_valid, 0);
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_done", frames_seen, f0);
    endtask

    task automatic reset_test();
        bit got;
        got        = 1'b0;
        ready_mode = 2;
        max_ctr    = 7'd5;
        ctr_select = 2'd0;
        step       = 10'd20;
        cr_offset  = '0;
        ci_offset  = '0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int n = 0; n < 1000 && !got; n++) begin
            @(posedge clk);
            #1;
            got = out_valid;
        end
        check("rst_drain_reached", got, 1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        #1 rst_n = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin : main
        int maxc, sel, stp, cro, cio;
        rst_n      = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        max_ctr    = '0;
        ctr_select = '0;
        step       = '0;
        cr_offset  = '0;
        ci_offset  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {busy, out_valid, frame_done, out_last, out_ctr, out_x, out_y}, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        check("model_c0", pix_ctr(0, 0, 127), 127);
        check("model_c2", pix_ctr(256, 0, 127), 2);
        check("model_cm4", pix_ctr(-512, 0, 127), 1);
        check("model_max0", pix_ctr(300, -100, 0), 0);

        run_frame(0, 0, 37, 100, 200, 0, 1'b0);
        run_frame(127, 3, 0, 0, 0, 0, 1'b0);
        run_frame(127, 0, 0, 0, 0, 0, 1'b0);

        for (int i = 0; i < 6; i++) begin
            maxc = $urandom_range(0, 127);
            sel  = $urandom_range(0, 3);
            stp  = $urandom_range(0, 80);
            cro  = $urandom_range(0, 1023);
            cio  = $urandom_range(0, 1023);
            run_frame(maxc, sel, stp, cro, cio, 0, 1'b0);
            run_frame(maxc, sel, stp, cro, cio, 1, 1'b1);
        end

        abort_test(1'b0);
        run_frame(20, 1, 30, 900, 950, 1, 1'b0);
        abort_test(1'b1);
        run_frame(127, 2, 13, 960, 1000, 0, 1'b0);

        abort = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        start = 1'b0;
        check("idle_abort_wins", busy, 0);

        reset_test();
        run_frame(50, 0, 25, 970, 980, 1, 1'b1);

        check("frame_count", frames_seen, frames_exp);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
